// File: rtl/n64_demux_ctrl_pkg.sv
// n64_demux_ctrl_pkg
//   Shared definitions for the N64 video demux controller:
//   - default colour word width,
//   - bit positions inside the demuxparams word,
//   - bit positions of the sync nibble on the video bus,
//   - field line-count thresholds (valid window and PAL split),
//   - field-state FSM encodings,
//   - a saturating line-counter increment helper.
package n64_demux_ctrl_pkg;

  localparam int COLOR_WIDTH_DEF = 7;

  // demuxparams word layout: {data_cnt[1:0], n64_480i, vmode, ndo_deblur, n15bit_mode}
  localparam int DP_DATA_CNT_HI = 5;
  localparam int DP_DATA_CNT_LO = 4;
  localparam int DP_N64_480I    = 3;
  localparam int DP_VMODE       = 2;
  localparam int DP_NDO_DEBLUR  = 1;
  localparam int DP_N15BIT      = 0;

  // Sync nibble on D_i[3:0] during nDSYNC=0: {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
  localparam int SYNC_NVSYNC = 3;
  localparam int SYNC_NHSYNC = 1;

  // Field line-count thresholds
  localparam logic [9:0] LINES_MIN = 10'd200;
  localparam logic [9:0] LINES_PAL = 10'd288;
  localparam logic [9:0] LINES_MAX = 10'd400;

  // Field-state FSM encodings
  localparam logic [1:0] ST_UNLOCKED  = 2'd0;
  localparam logic [1:0] ST_ONE_FIELD = 2'd1;
  localparam logic [1:0] ST_LOCKED    = 2'd2;

  // Add inc to a 10-bit counter, sticking at 1023 instead of wrapping.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v, input logic inc);
    logic [9:0] r;
    if (v == 10'h3FF) begin
      r = v;
    end else begin
      r = v + {9'd0, inc};
    end
    return r;
  endfunction

endpackage

// File: rtl/n64_demux_ctrl_field_meas.sv
// n64_field_meas
//   Counts lines per field, compares consecutive fields and tracks video lock.
//   Ports:
//     nCLK           in   video clock, all state changes on its falling edge
//     nRST           in   asynchronous active-low reset
//     hsync_fall_i   in   nHSYNC falling edge seen in this sync phase
//     vsync_fall_i   in   nVSYNC falling edge seen in this sync phase (field start)
//     locked_nxt_o   out  FSM will be LOCKED after this edge (combinational)
//     n64_480i_nxt_o out  next value of the n64_480i flag (combinational)
//     n64_480i_o     out  registered interlace flag (0 unless locked)
//     vmode_o        out  registered PAL flag (0 unless locked)
//     vlock_o        out  registered lock indication
module n64_field_meas
  import n64_demux_ctrl_pkg::*;
(
  input  logic nCLK,
  input  logic nRST,
  input  logic hsync_fall_i,
  input  logic vsync_fall_i,
  output logic locked_nxt_o,
  output logic n64_480i_nxt_o,
  output logic n64_480i_o,
  output logic vmode_o,
  output logic vlock_o
);

  logic [9:0] line_cnt_d, line_cnt_q;
  logic [9:0] prev_lines_d, prev_lines_q;
  logic [9:0] field_lines_s;
  logic       field_valid_s;
  logic [1:0] state_d, state_q;
  logic       n64_480i_d, n64_480i_q;
  logic       vmode_d, vmode_q;
  logic       vlock_d, vlock_q;

  // Line count including a coincident hsync edge, so a line that falls together
  // with nVSYNC still belongs to the field that is ending.
  always_comb begin
    field_lines_s = sat_inc10(line_cnt_q, hsync_fall_i);
    field_valid_s = (field_lines_s >= LINES_MIN) && (field_lines_s <= LINES_MAX);
  end

  // Line counter and previous-field line count.
  always_comb begin
    line_cnt_d   = field_lines_s;
    prev_lines_d = prev_lines_q;
    if (vsync_fall_i) begin
      line_cnt_d   = 10'd0;
      prev_lines_d = field_lines_s;
    end else begin
      line_cnt_d   = field_lines_s;
      prev_lines_d = prev_lines_q;
    end
  end

  // Field-state FSM, advanced only at field start.
  always_comb begin
    state_d = state_q;
    if (vsync_fall_i) begin
      if (!field_valid_s) begin
        state_d = ST_UNLOCKED;
      end else begin
        case (state_q)
          ST_UNLOCKED:  state_d = ST_ONE_FIELD;
          ST_ONE_FIELD: state_d = ST_LOCKED;
          ST_LOCKED:    state_d = ST_LOCKED;
          default:      state_d = ST_UNLOCKED;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Video mode flags: evaluated at field start, forced low unless locked.
  always_comb begin
    vmode_d    = vmode_q;
    n64_480i_d = n64_480i_q;
    if (vsync_fall_i) begin
      if (state_d == ST_LOCKED) begin
        vmode_d    = (field_lines_s >= LINES_PAL);
        n64_480i_d = (field_lines_s != prev_lines_q);
      end else begin
        vmode_d    = 1'b0;
        n64_480i_d = 1'b0;
      end
    end else begin
      vmode_d    = vmode_q;
      n64_480i_d = n64_480i_q;
    end
    vlock_d = (state_d == ST_LOCKED);
  end

  // State registers.
  always_ff @(negedge nCLK or negedge nRST) begin
    if (!nRST) begin
      line_cnt_q   <= 10'd0;
      prev_lines_q <= 10'd0;
      state_q      <= ST_UNLOCKED;
      n64_480i_q   <= 1'b0;
      vmode_q      <= 1'b0;
      vlock_q      <= 1'b0;
    end else begin
      line_cnt_q   <= line_cnt_d;
      prev_lines_q <= prev_lines_d;
      state_q      <= state_d;
      n64_480i_q   <= n64_480i_d;
      vmode_q      <= vmode_d;
      vlock_q      <= vlock_d;
    end
  end

  assign locked_nxt_o   = (state_d == ST_LOCKED);
  assign n64_480i_nxt_o = n64_480i_d;
  assign n64_480i_o     = n64_480i_q;
  assign vmode_o        = vmode_q;
  assign vlock_o        = vlock_q;

endmodule

// File: rtl/n64_demux_ctrl.sv
// n64_demux_ctrl
//   Tracks the N64 video bus phase, extracts sync edges and derives the
//   demux parameters used by the colour demultiplexer.
//   Ports:
//     nCLK          in   video clock, all logic on its falling edge
//     nRST          in   asynchronous active-low reset
//     nDSYNC        in   data-sync strobe, low during the sync nibble
//     D_i           in   video bus; [3:0] = {nVSYNC,nCLAMP,nHSYNC,nCSYNC} in sync phase
//     nDeBlur_i     in   user setting, 1 = deblur off
//     n15bit_mode_i in   user setting, 1 = full 21-bit colour
//     demuxparams_o out  {data_cnt[1:0], n64_480i, vmode, ndo_deblur, n15bit_mode}
//     vlock_o       out  video timing locked
//     desync_err_o  out  one-cycle pulse on a bus phase error
module n64_demux_ctrl
  import n64_demux_ctrl_pkg::*;
#(
  parameter int color_width = COLOR_WIDTH_DEF
)(
  input  logic                   nCLK,
  input  logic                   nRST,
  input  logic                   nDSYNC,
  input  logic [color_width-1:0] D_i,
  input  logic                   nDeBlur_i,
  input  logic                   n15bit_mode_i,
  output logic [5:0]             demuxparams_o,
  output logic                   vlock_o,
  output logic                   desync_err_o
);

  logic [1:0] data_cnt_d, data_cnt_q;
  logic       desync_err_d, desync_err_q;
  logic [3:0] sync_d, sync_q;
  logic       sync_seen_d, sync_seen_q;
  logic       hsync_fall_s, vsync_fall_s;
  logic       ndo_deblur_d, ndo_deblur_q;
  logic       n15bit_mode_d, n15bit_mode_q;
  logic [5:0] demuxparams_d, demuxparams_q;
  logic       locked_nxt_s, n64_480i_nxt_s, n64_480i_s, vmode_s;
  logic       unused_color_s;

  // Colour bits above the sync nibble carry no control information.
  assign unused_color_s = ^D_i[color_width-1:4];

  // Bus phase counter; an error is a sync arriving early or a count running past 11.
  always_comb begin
    if (nDSYNC) begin
      data_cnt_d   = data_cnt_q + 2'b01;
      desync_err_d = (data_cnt_q == 2'b11);
    end else begin
      data_cnt_d   = 2'b01;
      desync_err_d = (data_cnt_q != 2'b11);
    end
  end

  // Sync nibble capture and edge detection between consecutive sync phases.
  // sync_seen_q suppresses edges against the reset nibble after reset release.
  always_comb begin
    sync_d       = sync_q;
    sync_seen_d  = sync_seen_q;
    hsync_fall_s = 1'b0;
    vsync_fall_s = 1'b0;
    if (!nDSYNC) begin
      sync_d       = D_i[3:0];
      sync_seen_d  = 1'b1;
      hsync_fall_s = sync_seen_q & sync_q[SYNC_NHSYNC] & ~D_i[SYNC_NHSYNC];
      vsync_fall_s = sync_seen_q & sync_q[SYNC_NVSYNC] & ~D_i[SYNC_NVSYNC];
    end else begin
      sync_d       = sync_q;
      sync_seen_d  = sync_seen_q;
      hsync_fall_s = 1'b0;
      vsync_fall_s = 1'b0;
    end
  end

  n64_field_meas u_field_meas (
    .nCLK           (nCLK),
    .nRST           (nRST),
    .hsync_fall_i   (hsync_fall_s),
    .vsync_fall_i   (vsync_fall_s),
    .locked_nxt_o   (locked_nxt_s),
    .n64_480i_nxt_o (n64_480i_nxt_s),
    .n64_480i_o     (n64_480i_s),
    .vmode_o        (vmode_s),
    .vlock_o        (vlock_o)
  );

  // User settings are sampled at field start only; deblur uses the new 480i flag.
  always_comb begin
    ndo_deblur_d  = ndo_deblur_q;
    n15bit_mode_d = n15bit_mode_q;
    if (vsync_fall_s) begin
      n15bit_mode_d = n15bit_mode_i;
      if (locked_nxt_s) begin
        ndo_deblur_d = nDeBlur_i | n64_480i_nxt_s;
      end else begin
        ndo_deblur_d = 1'b1;
      end
    end else begin
      ndo_deblur_d  = ndo_deblur_q;
      n15bit_mode_d = n15bit_mode_q;
    end
  end

  // Output word assembled from registered state, so it trails data_cnt by one cycle.
  always_comb begin
    demuxparams_d = 6'b000000;
    demuxparams_d[DP_DATA_CNT_HI:DP_DATA_CNT_LO] = data_cnt_q;
    demuxparams_d[DP_N64_480I]   = n64_480i_s;
    demuxparams_d[DP_VMODE]      = vmode_s;
    demuxparams_d[DP_NDO_DEBLUR] = ndo_deblur_q;
    demuxparams_d[DP_N15BIT]     = n15bit_mode_q;
  end

  // State registers.
  always_ff @(negedge nCLK or negedge nRST) begin
    if (!nRST) begin
      data_cnt_q    <= 2'b00;
      desync_err_q  <= 1'b0;
      sync_q        <= 4'hF;
      sync_seen_q   <= 1'b0;
      ndo_deblur_q  <= 1'b1;
      n15bit_mode_q <= 1'b1;
      demuxparams_q <= 6'b000011;
    end else begin
      data_cnt_q    <= data_cnt_d;
      desync_err_q  <= desync_err_d;
      sync_q        <= sync_d;
      sync_seen_q   <= sync_seen_d;
      ndo_deblur_q  <= ndo_deblur_d;
      n15bit_mode_q <= n15bit_mode_d;
      demuxparams_q <= demuxparams_d;
    end
  end

  assign demuxparams_o = demuxparams_q;
  assign desync_err_o  = desync_err_q;

endmodule
